// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic initiator:
// FSM state encoding, command/response records and the timeout data word.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } wb_state_e;

    localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_cmd_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_initiator_timer.sv
// Saturating 16-bit bus-cycle timer; hit flags the last allowed cycle
// so the initiator can abandon the cycle on that clock edge.
module wb_initiator_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam logic [15:0] LIM_M1 = 16'(LIMIT - 1);

    logic [15:0] count;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign hit = enable && (count >= LIM_M1);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator with response hold and gap.
// Optional bus timeout enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned GAP_MIN        = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy
);

    wb_state_e   state;
    wb_cmd_t     cmd_q;
    wb_rsp_t     rsp_q;
    wb_rsp_t     bus_rsp;
    logic [15:0] gap_cnt;
    logic        gap_done;
    logic        to_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_initiator_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .clear    (state != ST_BUS),
        .enable   (state == ST_BUS),
        .hit      (to_hit)
    );
`else
    assign to_hit = 1'b0;
`endif

    assign gap_done = (32'(gap_cnt) + 32'd1) >= GAP_MIN;

    // ack beats a timeout landing on the same edge
    always_comb begin
        bus_rsp.dat = cmd_q.we ? 32'd0 : wbm_dat_i;
        bus_rsp.err = 1'b0;
        if (to_hit && !wbm_ack_i) begin
            bus_rsp.dat = WB_TIMEOUT_DATA;
            bus_rsp.err = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            rsp_q     <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_q.we  <= cmd_we;
                        cmd_q.adr <= cmd_adr;
                        cmd_q.dat <= cmd_dat;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i || to_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_q     <= bus_rsp;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // a lingering ack from the old slave holds us here
                    if (gap_done && !wbm_ack_i) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (gap_cnt != 16'hFFFF) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wbm_we_o  = cmd_q.we;
    assign wbm_adr_o = cmd_q.adr;
    assign wbm_dat_o = cmd_q.dat;
    assign rsp_dat   = rsp_q.dat;
`ifdef WB_INITIATOR_TIMEOUT_EN
    assign rsp_err   = rsp_q.err;
`else
    assign rsp_err   = 1'b0;
`endif
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: vector table with a response scoreboard,
// plus hand sequences for idle ack, timeout and mid-cycle reset.
module tb_wb_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    wb_initiator #(
        .TIMEOUT_CYCLES(TO),
        .GAP_MIN(1)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          waitc;
        logic [31:0] rdata;
        int          hold;
        int          linger;
        int          exp_wait;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   linger_left = 0;
    logic prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        prev_ack = wbm_ack_i;
        @(negedge clk);
        if (linger_left > 0) begin
            linger_left--;
            wbm_ack_i = (linger_left > 0);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input int waitc,
                                input logic [31:0] rd, input int hold,
                                input int linger, input int exp_wait);
        vec_t v;
        v.we       = we;
        v.adr      = adr;
        v.dat      = dat;
        v.waitc    = waitc;
        v.rdata    = rd;
        v.hold     = hold;
        v.linger   = linger;
        v.exp_wait = exp_wait;
        v.exp_dat  = we ? 32'd0 : rd;
        v.exp_err  = 1'b0;
        v.exp_stb  = waitc + 1;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int   w;
        int   cnt;
        logic bad;
        logic early;
        logic [31:0] d;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        w = 0;
        early = 1'b0;
        while (!cmd_ready && w < 50) begin
            if (wbm_cyc_o) early = 1'b1;
            tick();
            w++;
        end
        chk("cyc_before_hs", 32'(early), 32'd0);
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hs_timeout: got no cmd_ready required 1");
            cmd_valid = 1'b0;
            return;
        end
        if (v.exp_wait >= 0) chk("hs_wait", 32'(w), 32'(v.exp_wait));
        if (w > 0) chk("gap_ack_low", 32'(prev_ack), 32'd0);
        sb.push_back('{v.exp_dat, v.exp_err});
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cnt = 0;
        bad = 1'b0;
        while (wbm_stb_o && cnt < 2000) begin
            cnt++;
            if (!wbm_cyc_o || wbm_we_o !== v.we ||
                wbm_adr_o !== v.adr || wbm_dat_o !== v.dat)
                bad = 1'b1;
            if (cnt > v.waitc) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            tick();
        end
        chk("bus_fields", 32'(bad), 32'd0);
        chk("stb_cycles", 32'(cnt), 32'(v.exp_stb));
        wbm_dat_i   = $urandom;
        linger_left = v.linger;
        wbm_ack_i   = (v.linger > 0);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("cyc_low", 32'(wbm_cyc_o), 32'd0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got response required none");
        end else begin
            e = sb.pop_front();
            chk("rsp_dat", rsp_dat, e.dat);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        bad = 1'b0;
        for (int i = 0; i < v.hold; i++) begin
            d = rsp_dat;
            tick();
            if (rsp_valid !== 1'b1 || rsp_dat !== d || cmd_ready !== 1'b0)
                bad = 1'b1;
        end
        if (v.hold > 0) chk("hold_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("busy_gap", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        chk("reach_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int   c;
        logic bad;
        vec_t tv;

        vecs[0] = mk(1'b1, 32'h0080_0000, 32'h0000_001D, 2,
                     32'hFFFF_FFFF, 0, 0, -1);
        vecs[1] = mk(1'b0, 32'h0000_1000, 32'h0, 0,
                     32'h1234_5678, 0, 0, 1);
        vecs[2] = mk(1'b0, 32'h0000_2004, 32'h0, 1,
                     32'hA5A5_5A5A, 5, 0, 1);
        vecs[3] = mk(1'b1, 32'h0000_3008, 32'hCAFE_0001, 0,
                     32'h0, 0, 2, 1);
        vecs[4] = mk(1'b0, 32'h0000_400C, 32'h0, 0,
                     32'hCAFE_F00D, 0, 0, 2);
        vecs[5] = mk(1'b0, 32'h0000_5010, 32'h0, TO - 1,
                     32'h0BAD_F00D, 0, 0, 1);
        vecs[6] = mk(1'b1, 32'hFFFF_FFFC, 32'h8000_0001, 3,
                     32'h0, 2, 1, 1);

        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp", {rsp_dat[30:0], rsp_valid}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        wait_idle();
        bad = 1'b0;
        wbm_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        tick();
        chk("idle_ack_ignored", 32'(bad | rsp_valid), 32'd0);

`ifdef WB_INITIATOR_TIMEOUT_EN
        tv = mk(1'b0, 32'h0000_6000, 32'h0, 100000, 32'h0, 0, 0, -1);
        tv.exp_dat = 32'hDEAD_BEEF;
        tv.exp_err = 1'b1;
        tv.exp_stb = TO;
        run_txn(tv);
`else
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0000_6000;
        wait_idle();
        tick();
        cmd_valid = 1'b0;
        c = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wbm_cyc_o && wbm_stb_o) c++;
            tick();
        end
        chk("no_timeout_cyc", 32'(c), 32'd1000);
        chk("no_timeout_rsp", 32'(rsp_valid), 32'd0);
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        wait_idle();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_7000;
        cmd_dat   = 32'h0000_7777;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("bus2_stb", 32'(wbm_stb_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_cycstb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_adr", wbm_adr_o, 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        tick();
        if (rsp_valid !== 1'b0) bad = 1'b1;
        chk("rst_mid_no_rsp", 32'(bad), 32'd0);
        chk("rst_mid_ready_up", 32'(cmd_ready), 32'd1);

        tv = mk(1'b0, 32'h0000_8000, 32'h0, 1, 32'h5566_7788, 0, 0, 0);
        run_txn(tv);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a bus cycle waits for acknowledge (range 1..65535).
REQ-002 Parameter GAP_MIN, default 1: minimum idle cycles between the end of one bus cycle and the next wbm_cyc_o assertion.
REQ-003 wb_clk_i  input  1: the single clock; every flop is clocked on its rising edge.
REQ-004 wb_rst_ni  input  1: asynchronous, active-low reset.
REQ-005 cmd_valid  input  1: command offered.
REQ-006 cmd_ready  output  1: command accepted on the cycle both cmd_valid and cmd_ready are high.
REQ-007 cmd_we  input  1: 1 = write, 0 = read.
REQ-008 cmd_adr  input  32: byte address.
REQ-009 cmd_dat  input  32: write data.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each: Wishbone classic cycle, strobe and write enable.
REQ-011 wbm_adr_o, wbm_dat_o  output  32 each: bus address and write data.
REQ-012 wbm_dat_i  input  32: read data; wbm_ack_i  input  1: acknowledge.
REQ-013 rsp_valid  output  1: response held; rsp_ready  input  1: response consumed on the cycle both are high.
REQ-014 rsp_dat  output  32: read data, or 0 for writes; rsp_err  output  1: timeout occurred.
REQ-015 busy  output  1: high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, BUS, RESP, GAP.
REQ-017 IDLE: cmd_ready=1; on handshake, register the command, assert cyc/stb/we/adr/dat on the next cycle, and go to BUS.
REQ-018 BUS: cyc, stb, adr, dat and we are held stable until ack or timeout.
REQ-019 BUS, wbm_ack_i sampled high: capture wbm_dat_i (reads only), deassert cyc/stb on the next cycle, and go to RESP with rsp_err=0.
REQ-020 An ack already high in the first BUS cycle is accepted; zero-wait responders are legal.
REQ-021 RESP: rsp_valid=1 and rsp_dat/rsp_err held stable until rsp_ready; then go to GAP.
REQ-022 rsp_valid and rsp_ready high in the first RESP cycle: response completes in that cycle.
REQ-023 GAP: stay in GAP until GAP_MIN idle cycles have elapsed AND wbm_ack_i is sampled low; then go to IDLE. This tolerates responders whose ack lingers after cyc drops.
REQ-024 cmd_ready=0 in BUS, RESP and GAP; only one transaction is outstanding.
REQ-025 Latency: command handshake at edge N gives stb high in cycle N+1; with a 2-cycle responder, rsp_valid rises in cycle N+4.
REQ-026 The timeout counter is 16 bits, cleared on entry to BUS, and saturates; it never wraps.
REQ-027 Ack and the timeout limit reached in the same cycle: ack wins, rsp_err=0.
REQ-028 An ack seen in IDLE or RESP is ignored and produces no response.

Reset
REQ-029 Asserting wb_rst_ni low at any time, including mid-cycle in BUS, forces within the same cycle: state IDLE; cyc, stb, we, rsp_valid, rsp_err, busy = 0; adr, dat, rsp_dat = 0; counters = 0.
REQ-030 cmd_ready = 0 while reset is asserted, and 1 from the first clock edge after deassertion.
REQ-031 Reset deassertion is used unsynchronised; the integrator guarantees it is synchronous to wb_clk_i.

Configuration
REQ-032 Macro WB_INITIATOR_TIMEOUT_EN, when defined: in BUS, after TIMEOUT_CYCLES cycles without ack, deassert cyc/stb and go to RESP with rsp_err=1 and rsp_dat=32'hDEADBEEF.
REQ-033 Macro WB_INITIATOR_TIMEOUT_EN, when undefined: the timeout counter is not instantiated, BUS waits indefinitely, and rsp_err is tied to 0.

Structure
REQ-034 Shared package wb_pkg holds: the FSM state enum, the WB_TIMEOUT_DATA constant (32'hDEADBEEF), and the command/response record typedefs.
REQ-035 Sub-module wb_initiator_timer (clear, enable, saturating 16-bit count, limit compare) is instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-036 Write: adr=32'h00800000, dat=32'h0000001D, responder ack after 2 cycles -> stb held 3 cycles, we=1, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-037 Read: responder returns 32'h12345678 with a 0-wait ack -> rsp_dat=32'h12345678 and rsp_valid in cycle N+2.
REQ-038 Ack lingering 2 cycles after cyc drops, next command queued -> no cyc assertion until ack is low; exactly one response per command.
REQ-039 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles, rsp_err=1, rsp_dat=32'hDEADBEEF; macro undefined -> cyc stays high for 1000 cycles.
REQ-040 rsp_ready held low for 5 cycles -> rsp_valid and rsp_dat stable and cmd_ready=0 throughout; release completes the response and goes to GAP.
REQ-041 Reset asserted in the second BUS cycle -> cyc/stb low immediately, no response issued; a new command after release completes normally.
